// File: rtl/multicycle_control_unit.sv
// RV32I multicycle control FSM: sequences fetch/decode/execute/memory/writeback over a shared
// memory with a bounded-latency handshake, and drives every datapath enable and mux select.
module multicycle_control_unit #(
  parameter int unsigned ALUCTRL_W = 3,
  parameter bit          CSR_EN    = 1'b1,
  parameter int unsigned MEM_TMO   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           op,
  input  logic [2:0]           f3,
  input  logic                 f7,
  input  logic [4:0]           rs1_f,      // IR[19:15], rs1 index or zimm for CSR ops
  input  logic                 zero,
  input  logic                 lt,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_write,
  output logic                 adr_src,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 reg_write,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [ALUCTRL_W-1:0] alu_control,
  output logic [1:0]           res_src,
  output logic [2:0]           inm_src,
  output logic                 csr_w,
  output logic                 csr_inm,
  output logic                 fault,
  output logic [3:0]           state
);

  localparam int unsigned TMO_W = $clog2(MEM_TMO + 1);

  // ALU op codes: SHIFT lets the ALU pick SLL/SRL/SRA from IR[14:12]/IR[30]
  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_AND   = 3'd2;
  localparam logic [2:0] ALU_OR    = 3'd3;
  localparam logic [2:0] ALU_XOR   = 3'd4;
  localparam logic [2:0] ALU_SLT   = 3'd5;
  localparam logic [2:0] ALU_SLTU  = 3'd6;
  localparam logic [2:0] ALU_SHIFT = 3'd7;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXER, S_EXEI,
    S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LUI, S_AUIPC, S_CSR, S_FAULT
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [TMO_W-1:0]   r_tmo;
  logic [2:0]         w_alu;
  logic               w_mem_state;
  logic               w_wait;
  logic               w_tmo_hit;

  function automatic logic [2:0] alu_dec(input logic [2:0] fn3, input logic alt);
    case (fn3)
      3'b000:         return alt ? ALU_SUB : ALU_ADD;
      3'b001, 3'b101: return ALU_SHIFT;
      3'b010:         return ALU_SLT;
      3'b011:         return ALU_SLTU;
      3'b100:         return ALU_XOR;
      3'b110:         return ALU_OR;
      default:        return ALU_AND;
    endcase
  endfunction

  // Memory wait tracking; the counter is zero whenever no access is stalled
  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  assign w_wait      = w_mem_state && !mem_ready;
  assign w_tmo_hit   = w_wait && (r_tmo == TMO_W'(MEM_TMO - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_tmo   <= '0;
    end else begin
      r_state <= w_next;
      r_tmo   <= w_wait ? r_tmo + TMO_W'(1) : '0;
    end
  end

  always_comb begin
    w_next    = r_state;
    mem_req   = 1'b0;
    mem_write = 1'b0;
    adr_src   = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    reg_write = 1'b0;
    alu_src_a = 2'd0;
    alu_src_b = 2'd0;
    w_alu     = ALU_ADD;
    res_src   = 2'd0;
    inm_src   = 3'd0;
    csr_w     = 1'b0;
    csr_inm   = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'd2;
        res_src   = 2'd2;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          w_next   = S_DECODE;
        end else if (w_tmo_hit) begin
          w_next = S_FAULT;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd1;
        inm_src   = 3'd2;
        case (op)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_R:              w_next = S_EXER;
          OP_I:              w_next = S_EXEI;
          OP_BRANCH:         w_next = S_BRANCH;
          OP_JAL:            w_next = S_JAL;
          OP_JALR:           w_next = S_JALR;
          OP_LUI:            w_next = S_LUI;
          OP_AUIPC:          w_next = S_AUIPC;
          OP_SYSTEM:         w_next = CSR_EN ? S_CSR : S_FAULT;
          default:           w_next = S_FAULT;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'd2;
        alu_src_b = 2'd1;
        inm_src   = op[5] ? 3'd1 : 3'd0;
        w_next    = op[5] ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready)      w_next = S_MEMWB;
        else if (w_tmo_hit) w_next = S_FAULT;
      end
      S_MEMWB: begin
        res_src   = 2'd1;
        reg_write = 1'b1;
        w_next    = S_FETCH;
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready)      w_next = S_FETCH;
        else if (w_tmo_hit) w_next = S_FAULT;
      end
      S_EXER: begin
        alu_src_a = 2'd2;
        w_alu     = alu_dec(f3, f7);
        w_next    = S_ALUWB;
      end
      S_EXEI: begin
        alu_src_a = 2'd2;
        alu_src_b = 2'd1;
        w_alu     = alu_dec(f3, 1'b0);
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        w_next    = S_FETCH;
      end
      S_BRANCH: begin
        // Target precomputed in DECODE sits in the ALU result register
        alu_src_a = 2'd2;
        inm_src   = 3'd2;
        w_alu     = f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
        if (f3[2:1] == 2'b01) begin
          w_next = S_FAULT;
        end else begin
          pc_write = f3[2] ? (lt ^ f3[0]) : (zero ^ f3[0]);
          w_next   = S_FETCH;
        end
      end
      S_JAL: begin
        pc_write  = 1'b1;
        alu_src_a = 2'd1;
        alu_src_b = 2'd2;
        inm_src   = 3'd3;
        w_next    = S_ALUWB;
      end
      S_JALR: begin
        pc_write  = 1'b1;
        alu_src_a = 2'd1;
        alu_src_b = 2'd2;
        w_next    = S_ALUWB;
      end
      S_LUI: begin
        alu_src_a = 2'd3;  // constant zero operand
        alu_src_b = 2'd1;
        inm_src   = 3'd4;
        w_next    = S_ALUWB;
      end
      S_AUIPC: begin
        alu_src_b = 2'd1;
        inm_src   = 3'd4;
        w_next    = S_ALUWB;
      end
      S_CSR: begin
        if (f3[1:0] == 2'b00) begin
          w_next = S_FAULT;
        end else begin
          res_src   = 2'd3;
          reg_write = 1'b1;
          csr_inm   = f3[2];
          csr_w     = !(f3[1] && (rs1_f == 5'd0));
          w_next    = S_FETCH;
        end
      end
      S_FAULT: w_next = S_FAULT;
      default: w_next = S_FAULT;
    endcase
    // Strobes stay quiet while reset is held, whatever state is being left
    if (rst) begin
      mem_req   = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
      csr_w     = 1'b0;
    end
  end

  assign alu_control = ALUCTRL_W'(w_alu);
  assign fault       = (r_state == S_FAULT);
  assign state       = r_state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: builds a per-cycle expected trace for each instruction
// from the instruction class and chosen memory latencies, then replays it against the DUT.
module tb_multicycle_control_unit;

  localparam int TMO = 16;

  localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MEMADR = 2, ST_MEMRD = 3, ST_MEMWB = 4,
                 ST_MEMWR = 5, ST_EXER = 6, ST_EXEI = 7, ST_ALUWB = 8, ST_BRANCH = 9,
                 ST_JAL = 10, ST_JALR = 11, ST_LUI = 12, ST_AUIPC = 13, ST_CSR = 14,
                 ST_FAULT = 15;
  localparam int A_ADD = 0, A_SUB = 1, A_AND = 2, A_OR = 3, A_XOR = 4, A_SLT = 5,
                 A_SLTU = 6, A_SHIFT = 7;
  // strobe vector bits: {mem_req, mem_write, ir_write, pc_write, reg_write, csr_w, fault}
  localparam int B_REQ = 64, B_WR = 32, B_IR = 16, B_PC = 8, B_RW = 4, B_CSR = 2, B_FLT = 1;

  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111,
                         OP_SYS = 7'b1110011;

  logic       clk, rst;
  logic [6:0] op;
  logic [2:0] f3;
  logic       f7, zero, lt, mem_ready;
  logic [4:0] rs1_f;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, res_src;
  logic [2:0] alu_control, inm_src;
  logic       csr_w, csr_inm, fault;
  logic [3:0] state;

  multicycle_control_unit #(.ALUCTRL_W(3), .CSR_EN(1'b1), .MEM_TMO(TMO)) dut (
    .clk(clk), .rst(rst), .op(op), .f3(f3), .f7(f7), .rs1_f(rs1_f), .zero(zero), .lt(lt),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_control(alu_control), .res_src(res_src), .inm_src(inm_src),
    .csr_w(csr_w), .csr_inm(csr_inm), .fault(fault), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit rdy;
    int st;
    int strb;
    int adr;
    int res;
    int alu;
    int cinm;
  } ent_t;

  ent_t q[$];
  int   n_chk = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d want=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic add(input bit rdy, input int st, input int strb, input int adr = -1,
                     input int res = -1, input int alu = -1, input int cinm = -1);
    ent_t e;
    e.rdy = rdy; e.st = st; e.strb = strb; e.adr = adr; e.res = res; e.alu = alu; e.cinm = cinm;
    q.push_back(e);
  endtask

  function automatic bit rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic int alu_exp(input logic [2:0] fn3, input bit rtype, input bit fn7);
    case (fn3)
      3'd0:       return (rtype && fn7) ? A_SUB : A_ADD;
      3'd1, 3'd5: return A_SHIFT;
      3'd2:       return A_SLT;
      3'd3:       return A_SLTU;
      3'd4:       return A_XOR;
      3'd6:       return A_OR;
      default:    return A_AND;
    endcase
  endfunction

  // A memory access stalled for wm cycles; reaching TMO stalls ends in a fault
  task automatic memwait(input int st, input int strb, input int wm, output bit hit);
    for (int i = 0; i < wm && i < TMO; i++) add(1'b0, st, strb, 1);
    hit = (wm >= TMO);
    if (!hit) add(1'b1, st, strb, 1);
  endtask

  task automatic gen(input logic [6:0] o, input logic [2:0] fn3, input bit fn7,
                     input logic [4:0] r1, input bit z, input bit l, input int wf,
                     input int wm, output bit flt);
    bit taken, ro;
    q.delete();
    flt = 1'b0;
    op = o; f3 = fn3; f7 = fn7; rs1_f = r1; zero = z; lt = l;
    for (int i = 0; i < wf && i < TMO; i++) add(1'b0, ST_FETCH, B_REQ, 0);
    if (wf >= TMO) begin
      flt = 1'b1;
    end else begin
      add(1'b1, ST_FETCH, B_REQ | B_IR | B_PC, 0, -1, A_ADD);
      add(rbit(), ST_DECODE, 0);
      case (o)
        OP_LOAD: begin
          add(rbit(), ST_MEMADR, 0, -1, -1, A_ADD);
          memwait(ST_MEMRD, B_REQ, wm, flt);
          if (!flt) add(rbit(), ST_MEMWB, B_RW, -1, 1);
        end
        OP_STORE: begin
          add(rbit(), ST_MEMADR, 0, -1, -1, A_ADD);
          memwait(ST_MEMWR, B_REQ | B_WR, wm, flt);
        end
        OP_R, OP_I: begin
          add(rbit(), (o == OP_R) ? ST_EXER : ST_EXEI, 0, -1, -1, alu_exp(fn3, o == OP_R, fn7));
          add(rbit(), ST_ALUWB, B_RW, -1, 0);
        end
        OP_BR: begin
          if (fn3 == 3'd2 || fn3 == 3'd3) begin
            add(rbit(), ST_BRANCH, 0);
            flt = 1'b1;
          end else begin
            case (fn3)
              3'd0:    taken = z;
              3'd1:    taken = !z;
              3'd4:    taken = l;
              3'd5:    taken = !l;
              3'd6:    taken = l;
              default: taken = !l;
            endcase
            add(rbit(), ST_BRANCH, taken ? B_PC : 0, -1, 0,
                (fn3 == 3'd0 || fn3 == 3'd1) ? A_SUB : ((fn3 >= 3'd6) ? A_SLTU : A_SLT));
          end
        end
        OP_JAL, OP_JALR: begin
          add(rbit(), (o == OP_JAL) ? ST_JAL : ST_JALR, B_PC);
          add(rbit(), ST_ALUWB, B_RW, -1, 0);
        end
        OP_LUI, OP_AUIPC: begin
          add(rbit(), (o == OP_LUI) ? ST_LUI : ST_AUIPC, 0);
          add(rbit(), ST_ALUWB, B_RW, -1, 0);
        end
        OP_SYS: begin
          if (fn3 == 3'd0 || fn3 == 3'd4) begin
            add(rbit(), ST_CSR, 0);
            flt = 1'b1;
          end else begin
            // CSRRS/CSRRC (and immediate forms) with a zero source only read
            ro = (fn3 == 3'd2 || fn3 == 3'd3 || fn3 == 3'd6 || fn3 == 3'd7) && (r1 == 5'd0);
            add(rbit(), ST_CSR, B_RW | (ro ? 0 : B_CSR), -1, 3, -1, (fn3 >= 3'd4) ? 1 : 0);
          end
        end
        default: flt = 1'b1;
      endcase
    end
    if (flt) for (int i = 0; i < 20; i++) add(rbit(), ST_FAULT, B_FLT);
  endtask

  // Called at a falling edge; leaves the bench at a falling edge
  task automatic run_q(input int upto);
    ent_t e;
    for (int i = 0; i < q.size() && i < upto; i++) begin
      e = q[i];
      mem_ready = e.rdy;
      #1;
      check("state", int'(state), e.st);
      check("strobes", int'({mem_req, mem_write, ir_write, pc_write, reg_write, csr_w, fault}), e.strb);
      if (e.adr >= 0)  check("adr_src", int'(adr_src), e.adr);
      if (e.res >= 0)  check("res_src", int'(res_src), e.res);
      if (e.alu >= 0)  check("alu_control", int'(alu_control), e.alu);
      if (e.cinm >= 0) check("csr_inm", int'(csr_inm), e.cinm);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b0;
    #1;
    check("rst_strobes", int'({mem_req, mem_write, ir_write, pc_write, reg_write, csr_w}), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_state", int'(state), ST_FETCH);
    check("rst_fault", int'(fault), 0);
  endtask

  task automatic run(input logic [6:0] o, input logic [2:0] fn3, input bit fn7,
                     input logic [4:0] r1, input bit z, input bit l, input int wf, input int wm);
    bit flt;
    gen(o, fn3, fn7, r1, z, l, wf, wm, flt);
    run_q(q.size());
    if (flt) do_reset();
  endtask

  function automatic int rwait();
    int r;
    r = $urandom_range(0, 24);
    if (r < 20) return r % 4;
    if (r < 22) return TMO - 1;
    if (r == 22) return TMO;
    return 5;
  endfunction

  logic [6:0] ops[14];
  bit         flt_mid;

  initial begin
    ops = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYS,
            7'b0000000, 7'b1111111, 7'b0001111, 7'b1010011};
    rst = 1'b1; op = '0; f3 = '0; f7 = 1'b0; rs1_f = '0; zero = 1'b0; lt = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    do_reset();

    run(OP_R, 3'd0, 1'b0, 5'd1, 1'b0, 1'b0, 0, 0);     // ADD
    run(OP_R, 3'd0, 1'b1, 5'd1, 1'b0, 1'b0, 1, 0);     // SUB
    run(OP_I, 3'd0, 1'b1, 5'd1, 1'b0, 1'b0, 0, 0);     // ADDI ignores IR[30]
    run(OP_LOAD, 3'd2, 1'b0, 5'd2, 1'b0, 1'b0, 0, 3);  // LW, 3 stall cycles
    run(OP_STORE, 3'd2, 1'b0, 5'd2, 1'b0, 1'b0, 2, 1); // SW
    run(OP_BR, 3'd1, 1'b0, 5'd0, 1'b1, 1'b0, 0, 0);    // BNE not taken
    run(OP_BR, 3'd1, 1'b0, 5'd0, 1'b0, 1'b0, 0, 0);    // BNE taken
    run(OP_BR, 3'd6, 1'b0, 5'd0, 1'b0, 1'b1, 0, 0);    // BLTU taken
    run(OP_BR, 3'd5, 1'b0, 5'd0, 1'b0, 1'b0, 0, 0);    // BGE taken
    run(OP_JAL, 3'd0, 1'b0, 5'd0, 1'b0, 1'b0, 0, 0);
    run(OP_LUI, 3'd0, 1'b0, 5'd0, 1'b0, 1'b0, 0, 0);
    run(OP_SYS, 3'd2, 1'b0, 5'd0, 1'b0, 1'b0, 0, 0);   // CSRRS x5, mstatus, x0
    run(OP_SYS, 3'd5, 1'b0, 5'd3, 1'b0, 1'b0, 0, 0);   // CSRRWI
    run(7'b0000000, 3'd0, 1'b0, 5'd0, 1'b0, 1'b0, 0, 0);
    run(OP_R, 3'd0, 1'b0, 5'd0, 1'b0, 1'b0, TMO - 1, 0); // ready on the last allowed cycle
    run(OP_R, 3'd0, 1'b0, 5'd0, 1'b0, 1'b0, TMO, 0);     // fetch timeout
    run(OP_STORE, 3'd2, 1'b0, 5'd0, 1'b0, 1'b0, 0, TMO); // store timeout
    run(OP_BR, 3'd2, 1'b0, 5'd0, 1'b0, 1'b0, 0, 0);      // bad branch f3
    run(OP_SYS, 3'd0, 1'b0, 5'd0, 1'b0, 1'b0, 0, 0);     // ECALL

    // Reset in the middle of a stalled load read
    gen(OP_LOAD, 3'd2, 1'b0, 5'd1, 1'b0, 1'b0, 0, 10, flt_mid);
    run_q(7);
    do_reset();

    for (int n = 0; n < 200; n++) begin
      run(ops[$urandom_range(0, 13)], 3'($urandom_range(0, 7)), rbit(),
          5'($urandom_range(0, 3)), rbit(), rbit(), rwait(), rwait());
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
